cmult_pipe: RTL and testbench
=============================

// Module: cmult_pipe
// PURPOSE
//  Parametrised, pipelined SW x SW multiplier with a valid/ready handshake on both sides.
//  Optional signed operation and a run-time approximate mode that truncates operand LSBs.
//  Drop-in successor to the combinational 2-operand multiplier.
//  Sits inside the approximate-arithmetic datapaths; upstream and downstream may stall.
// PARAMETERS
//  SW      24  operand width in bits (>=2)
//  STAGES  3   pipeline depth = input-to-output latency in cycles (>=1)
//  TRUNC   4   operand LSBs forced to 0 when Approx_i=1 (0..SW-1; 0 disables approximation)
//  SIGNED  0   0: unsigned operands/product; 1: two's-complement operands/product
// PORTS
//  clk       in   1     clock, all state on rising edge
//  rst       in   1     asynchronous, active-high reset
//  Data_A_i  in   SW    operand A
//  Data_B_i  in   SW    operand B
//  Approx_i  in   1     1: approximate mode for this operation (sampled with operands)
//  Valid_i   in   1     operands valid
//  Ready_o   out  1     block accepts operands this cycle
//  Data_S_o  out  2*SW  product, registered
//  Valid_o   out  1     Data_S_o valid
//  Ready_i   in   1     downstream accepts Data_S_o this cycle
// BEHAVIOUR
//  Reset: all stage valid bits=0, Valid_o=0, Data_S_o=0; takes effect immediately, async.
//  Reset mid-operation: every in-flight operation is discarded; no partial result is ever emitted.
//  Advance enable: en = ~Valid_o | Ready_i; Ready_o = en (combinational, no Valid_i dependency).
//  Accept: Valid_i & Ready_o in cycle N -> result on Data_S_o with Valid_o=1 from edge N+STAGES,
//   absent stalls; each cycle with en=0 adds one cycle of latency.
//  en=0: every stage register, including its valid bit, holds; Data_S_o and Valid_o stable.
//  en=1: all stages shift by one; stage 0 loads operands and valid = Valid_i.
//  Bubbles are carried as valid=0 entries, not compressed.
//  Throughput: one operation per cycle while Ready_i=1.
//  Ordering: results leave in acceptance order; no drop, no duplicate.
//  Output hold: Data_S_o holds while Valid_o=1 & Ready_i=0.
//  Bubble data: Data_S_o when Valid_o=0 is don't-care, but it is never X after reset.
//  Approximate mode: when Approx_i=1 at acceptance, bits [TRUNC-1:0] of both operands
//   are zeroed before multiplying. Exact: S = A*B; approximate: S = (A & M)*(B & M),
//   M = ~((1<<TRUNC)-1).
//  Width rules: product is full 2*SW bits; no overflow or saturation possible.
//   SIGNED=0: zero-extend. SIGNED=1: sign-extend.
//   SIGNED=1 edge: -2^(SW-1) * -2^(SW-1) = +2^(2SW-2), representable.
//  Pipelining split (timing only, not architecture): stage 0 registers the masked operands,
//   the multiply sits between stage 0 and 1, and stages 2..STAGES-1 are retiming registers.
//  STAGES=1: the single stage registers the product directly.
//  Simultaneous: an accept and an output handshake in the same cycle are legal with a full pipe.
//  Valid_i=1 while Ready_o=0: input is ignored; upstream must hold its operands.
// TESTING (SW=8, STAGES=3, TRUNC=2 unless stated)
//  1. A=200, B=150, Approx_i=0, Ready_i=1, accepted at cycle 0 -> Valid_o=1 at cycle 3,
//     Data_S_o=30000 (0x7530), Valid_o=0 at cycle 4.
//  2. A=0x0F, B=0x0F, Approx_i=1 -> 0x0C*0x0C = 144.
//     Same operands with Approx_i=0 -> 225.
//     A=0xFF, B=0xFF exact -> 65025 (0xFE01).
//  3. Stream 1*1..6*6 back-to-back, Ready_i=0 in cycles 4-7 -> Ready_o=0 while stalled,
//     Data_S_o held at 1, outputs 1,4,9,16,25,36 in order, none lost or repeated.
//  4. SIGNED=1: A=-3 (0xFD), B=5 -> 0xFFF1 (-15).
//     A=B=0x80 -> 0x4000 (+16384).
//  5. Three ops in flight, rst pulsed between clock edges -> Valid_o=0 and Data_S_o=0 at once;
//     after release, no stale result appears; next op has normal latency.
//  6. Random constrained stimulus with random Valid_i/Ready_i, SIGNED in {0,1}, TRUNC in {0,3}
//     -> scoreboard against the reference model, ordering preserved, zero mismatches.

Source files
------------

// File: rtl/cmult_pipe.sv
// Pipelined SW x SW multiplier, optional signed and LSB-truncating approximate mode; latency STAGES.
// One shared advance enable: the whole pipe freezes when the output is valid and not taken.
module cmult_pipe #(
  parameter int SW     = 24,
  parameter int STAGES = 3,
  parameter int TRUNC  = 4,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  input  logic            Approx_i,
  input  logic            Valid_i,
  output logic            Ready_o,
  output logic [2*SW-1:0] Data_S_o,
  output logic            Valid_o,
  input  logic            Ready_i
);

  localparam logic [SW-1:0] MASK = ~((SW'(1) << TRUNC) - SW'(1));

  logic          en;
  logic [SW-1:0] a_m;
  logic [SW-1:0] b_m;

  assign en      = ~Valid_o | Ready_i;
  assign Ready_o = en;
  assign a_m     = Approx_i ? (Data_A_i & MASK) : Data_A_i;
  assign b_m     = Approx_i ? (Data_B_i & MASK) : Data_B_i;

  // Extending both operands to 2*SW makes the truncated product exact for either signedness.
  function automatic logic [2*SW-1:0] mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [2*SW-1:0] ea;
    logic [2*SW-1:0] eb;
    if (SIGNED != 0) begin
      ea = {{SW{a[SW-1]}}, a};
      eb = {{SW{b[SW-1]}}, b};
    end else begin
      ea = {{SW{1'b0}}, a};
      eb = {{SW{1'b0}}, b};
    end
    return ea * eb;
  endfunction

  generate
    if (STAGES == 1) begin : g_single
      logic [2*SW-1:0] p;
      logic            v;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= 1'b0;
          p <= '0;
        end else if (en) begin
          v <= Valid_i;
          p <= mul(a_m, b_m);
        end
      end

      assign Data_S_o = p;
      assign Valid_o  = v;
    end else begin : g_multi
      logic [SW-1:0]     a_q;
      logic [SW-1:0]     b_q;
      logic [STAGES-1:0] v;
      logic [2*SW-1:0]   p [1:STAGES-1];

      // Stage 0 holds masked operands; stage 1 the product; the rest are retiming slots.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v   <= '0;
          a_q <= '0;
          b_q <= '0;
          for (int i = 1; i < STAGES; i++) p[i] <= '0;
        end else if (en) begin
          v    <= {v[STAGES-2:0], Valid_i};
          a_q  <= a_m;
          b_q  <= b_m;
          p[1] <= mul(a_q, b_q);
          for (int i = 2; i < STAGES; i++) p[i] <= p[i-1];
        end
      end

      assign Data_S_o = p[STAGES-1];
      assign Valid_o  = v[STAGES-1];
    end
  endgenerate

endmodule

// File: tb/tb_cmult_pipe.sv
// Bench for cmult_pipe: six SW=8/STAGES=3 instances covering SIGNED x TRUNC {2,0,3},
// driven in lockstep and scored against an arithmetic reference model.
module tb_cmult_pipe;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a, b;
  logic        ap, vi, ri;
  logic        ro [N];
  logic        vo [N];
  logic [15:0] s  [N];

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] sb [$];
  logic [15:0] obs0 [$];
  logic [15:0] obs1 [$];
  bit          hold_pend;
  logic [16:0] hold_val;

  function automatic int sg_of(input int i);
    return i % 2;
  endfunction

  function automatic int tr_of(input int i);
    return (i < 2) ? 2 : ((i < 4) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    cmult_pipe #(
      .SW(8), .STAGES(3),
      .TRUNC((g < 2) ? 2 : ((g < 4) ? 0 : 3)),
      .SIGNED(g % 2)
    ) u_dut (
      .clk(clk), .rst(rst),
      .Data_A_i(a), .Data_B_i(b), .Approx_i(ap), .Valid_i(vi),
      .Ready_o(ro[g]), .Data_S_o(s[g]), .Valid_o(vo[g]), .Ready_i(ri)
    );
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Product of the (optionally truncated) operands as plain integers.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                          input logic apx, input int sg, input int tr);
    int xm, ym, p;
    xm = int'(x);
    ym = int'(y);
    if (apx) begin
      xm = (xm / (1 << tr)) * (1 << tr);
      ym = (ym / (1 << tr)) * (1 << tr);
    end
    if (sg != 0 && xm >= 128) xm -= 256;
    if (sg != 0 && ym >= 128) ym -= 256;
    p = xm * ym;
    return p[15:0];
  endfunction

  // One clock cycle: inputs already driven; score handshakes, then move to the next negedge.
  task automatic step(output bit acc);
    logic [16:0] e;
    #1;
    if (hold_pend) check("hold", {15'd0, vo[0], s[0]}, {15'd0, hold_val});
    hold_pend = vo[0] && !ri;
    hold_val  = {vo[0], s[0]};
    acc = vi && ro[0];
    if (vo[0] && ri) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < N; i++)
          check($sformatf("sb_dat%0d", i), {16'd0, s[i]},
                {16'd0, ref_mul(e[15:8], e[7:0], e[16], sg_of(i), tr_of(i))});
        obs0.push_back(s[0]);
        obs1.push_back(s[1]);
      end
    end
    if (acc) sb.push_back({ap, a, b});
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    bit acc;
    vi = 1'b0;
    ri = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (sb.size() == 0 && !vo[0]) break;
      step(acc);
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    bit acc;
    int ptr;
    logic [7:0] ta [5];
    logic [7:0] tb [5];
    logic       tx [5];

    rst = 1'b1; a = '0; b = '0; ap = 1'b0; vi = 1'b0; ri = 1'b1;
    hold_pend = 1'b0; hold_val = '0;
    @(negedge clk);
    #1;
    check("rst_vld0", vo[0], 0);
    check("rst_dat0", s[0], 0);
    check("rst_vld1", vo[1], 0);
    check("rst_dat1", s[1], 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic latency: accept in cycle 0, result visible only in cycle 3
    a = 8'd200; b = 8'd150; ap = 1'b0; vi = 1'b1; ri = 1'b1;
    step(acc);
    check("t1_acc", acc, 1);
    vi = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("t1_vld_c%0d", c), vo[0], (c == 3) ? 1 : 0);
      if (c == 3) check("t1_dat", s[0], 16'd30000);
      step(acc);
    end

    // Approximate vs exact, extreme unsigned, and signed corner cases
    ta = '{8'h0F, 8'h0F, 8'hFF, 8'hFD, 8'h80};
    tb = '{8'h0F, 8'h0F, 8'hFF, 8'h05, 8'h80};
    tx = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    obs0.delete(); obs1.delete();
    for (int i = 0; i < 5; i++) begin
      a = ta[i]; b = tb[i]; ap = tx[i]; vi = 1'b1; ri = 1'b1;
      step(acc);
    end
    drain(20);
    check("t2_count", obs0.size(), 5);
    if (obs0.size() == 5) begin
      check("t2_apx", obs0[0], 16'd144);
      check("t2_exact", obs0[1], 16'd225);
      check("t2_ffff", obs0[2], 16'hFE01);
      check("t4_neg", obs1[3], 16'hFFF1);
      check("t4_minmin", obs1[4], 16'h4000);
    end

    // Back-to-back stream with a 4-cycle downstream stall
    obs0.delete();
    ptr = 0;
    ap = 1'b0;
    for (int c = 0; c < 40 && obs0.size() < 6; c++) begin
      vi = (ptr < 6);
      a = 8'(ptr + 1);
      b = 8'(ptr + 1);
      ri = !(c >= 3 && c <= 6);
      if (c >= 3 && c <= 6) begin
        #1;
        check($sformatf("t3_rdy_c%0d", c), ro[0], 0);
        check($sformatf("t3_held_c%0d", c), {vo[0], s[0]}, {1'b1, 16'd1});
      end
      step(acc);
      if (acc) ptr++;
    end
    drain(20);
    check("t3_count", obs0.size(), 6);
    if (obs0.size() == 6)
      for (int i = 0; i < 6; i++) check($sformatf("t3_ord%0d", i), obs0[i], (i + 1) * (i + 1));

    // Async reset with three operations in flight
    a = 8'd7;  b = 8'd9;  vi = 1'b1; ri = 1'b1; step(acc);
    a = 8'd10; b = 8'd11; step(acc);
    a = 8'd12; b = 8'd13; step(acc);
    vi = 1'b0;
    #1;
    check("t5_pre_vld", vo[0], 1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("t5_vld%0d", i), vo[i], 0);
      check($sformatf("t5_dat%0d", i), s[i], 0);
    end
    rst = 1'b0;
    sb.delete();
    hold_pend = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("t5_idle%0d", c), vo[0], 0);
      step(acc);
    end
    obs0.delete();
    a = 8'd20; b = 8'd30; vi = 1'b1;
    step(acc);
    vi = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("t5_lat_c%0d", c), vo[0], (c == 3) ? 1 : 0);
      step(acc);
    end
    check("t5_dat_after", (obs0.size() == 1) ? obs0[0] : 16'hDEAD, 16'd600);

    // Random traffic with random stalls; upstream holds operands until accepted
    acc = 1'b1;
    vi = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!vi || acc) begin
        vi = ($urandom_range(0, 3) != 0);
        a  = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
        b  = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
        ap = 1'($urandom);
      end
      ri = ($urandom_range(0, 2) != 0);
      step(acc);
    end
    drain(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
